// File: rtl/rf_pkg.sv
// Shared sizing and types for the register file and its busy-bit scoreboard.
// Default widths; modules derive the address width from NUM_REGS.
package rf_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: combinational RAW/WAW stall and ack, busy/pending_cnt update next edge.
// Stall holds the issue off until the producer's writeback clears (or is clearing) the busy bit.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic              RE1,
    input  logic              RE2,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    output logic              stall,
    output logic              issue_ack,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wb_en;
    logic                set_en;
    logic                clr_dec;

    assign wb_en = WE3 && !(ZERO_REG && A3 == '0);

    // A register finishing writeback this cycle is already forwarded, so it is not a hazard.
    always_comb begin
        busy_eff = busy;
        if (wb_en) busy_eff[A3] = 1'b0;
    end

    assign stall     = issue_valid && ((RE1 && busy_eff[A1]) ||
                                       (RE2 && busy_eff[A2]) ||
                                       (issue_we && busy_eff[issue_rd]));
    assign issue_ack = issue_valid && !stall;
    assign set_en    = issue_ack && issue_we && !(ZERO_REG && issue_rd == '0);
    assign clr_dec   = wb_en && busy[A3];

    // Set is applied after clear so a new producer keeps the bit when the old one retires.
    always_comb begin
        busy_nxt = busy;
        if (wb_en)  busy_nxt[A3]       = 1'b0;
        if (set_en) busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            case ({set_en, clr_dec})
                2'b10:   pending_cnt <= pending_cnt + CNT_ONE;
                2'b01:   pending_cnt <= pending_cnt - CNT_ONE;
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two write-first bypassed read ports, one writeback port and a hazard scoreboard.
// Reads and stall are zero latency; writes land on the next edge; stall backpressures decode.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        A1,
    input  logic [ADDR_W-1:0]        A2,
    input  logic                     RE1,
    input  logic                     RE2,
    output logic signed [DATA_W-1:0] RD1,
    output logic signed [DATA_W-1:0] RD2,
    input  logic                     WE3,
    input  logic [ADDR_W-1:0]        A3,
    input  logic signed [DATA_W-1:0] WD3,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic                     stall,
    output logic                     issue_ack,
    output logic [ADDR_W:0]          pending_cnt
);

    logic [DATA_W-1:0] reg_file [NUM_REGS];
    logic              wb_en;

    assign wb_en = WE3 && !(ZERO_REG && A3 == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
        end else if (wb_en) begin
            reg_file[A3] <= WD3;
        end
    end

    always_comb begin
        if (ZERO_REG && A1 == '0)  RD1 = '0;
        else if (WE3 && A3 == A1)  RD1 = WD3;
        else                       RD1 = reg_file[A1];
    end

    always_comb begin
        if (ZERO_REG && A2 == '0)  RD2 = '0;
        else if (WE3 && A3 == A2)  RD2 = WD3;
        else                       RD2 = reg_file[A2];
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .A1          (A1),
        .A2          (A2),
        .RE1         (RE1),
        .RE2         (RE2),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .WE3         (WE3),
        .A3          (A3),
        .stall       (stall),
        .issue_ack   (issue_ack),
        .pending_cnt (pending_cnt)
    );

endmodule
